elastic_buf: RTL and testbench
==============================

// Module: elastic_buf
// PURPOSE
//   Parametrised successor to the 3-state transparent skid buffer: an in-order,
//   DEPTH-entry valid/ready elastic buffer with fully registered in_ready,
//   out_valid and out_data.
//   Used to cut timing on long valid/ready channels.
//   Also absorbs bursts on record/replay paths, using level/almost_full for
//   upstream throttling.
// PARAMETERS
//   DATA_WIDTH    32         payload width in bits
//   DEPTH         4          total entries, output register included; >=2,
//                            need not be a power of 2
//   PASS_STALL    0          1: in_ready is also gated by the previous
//                            cycle's out_ready
//   AFULL_THRESH  DEPTH-1    almost_full asserts when level >= AFULL_THRESH;
//                            range 1..DEPTH
// PORTS
//   clk          in   1                     clock, all logic on posedge
//   rstn         in   1                     synchronous, active-low reset
//   in_valid     in   1                     upstream beat valid
//   in_data      in   DATA_WIDTH            upstream payload
//   in_ready     out  1                     registered; buffer accepts a beat
//   out_valid    out  1                     registered; out_data holds oldest entry
//   out_data     out  DATA_WIDTH            registered payload
//   out_ready    in   1                     downstream accepts
//   level        out  $clog2(DEPTH+1)       registered occupancy, 0..DEPTH
//   almost_full  out  1                     registered, level >= AFULL_THRESH
// BEHAVIOUR
//   - Handshake
//     - insert = in_valid & in_ready; remove = out_valid & out_ready.
//     - Upstream holds in_data stable while in_valid & !in_ready.
//     - out_valid/out_data are held until remove.
//   - Level
//     - level_next = level + insert - remove.
//     - insert with level==DEPTH is impossible: in_ready is 0 there.
//     - remove with level==0 is impossible: out_valid is 0 there.
//   - Registered flags, updated every cycle from level_next:
//     - out_valid   <= (level_next != 0)
//     - in_ready    <= (level_next != DEPTH) & (!PASS_STALL | out_ready)
//     - almost_full <= (level_next >= AFULL_THRESH)
//   - Latency
//     - Insert into an empty buffer at cycle t gives out_valid=1 and
//       out_data=that beat at t+1.
//   - Throughput: 1 beat/cycle sustained whenever out_ready=1
//     (PASS_STALL=0).
//   - Storage and ordering
//     - Ring of DEPTH entries; rd/wr pointers wrap DEPTH-1 -> 0.
//     - Strict FIFO order; no beat is dropped or duplicated.
//   - Simultaneous insert+remove
//     - level is unchanged.
//     - At level 1, out_data takes in_data.
//     - Otherwise out_data takes the next stored entry.
//   - out_data when out_valid=0: holds last value (stable, not X).
//   - Reset (synchronous, any cycle, including mid-burst)
//     - out_valid=0, in_ready=0, almost_full=0, level=0, out_data=0,
//       pointers=0.
//     - All stored beats are discarded.
//     - in_ready rises on the first cycle after rstn deasserts
//       (with PASS_STALL=1, also requires out_ready).
// CONFIGURATION
//   ELASTIC_BUF_PERF_EN
//     - Defined: adds outputs perf_xfer_cnt[31:0] and perf_full_cnt[31:0].
//       - perf_xfer_cnt increments on each remove.
//       - perf_full_cnt increments each cycle with in_valid & !in_ready.
//       - Both wrap 2^32-1 -> 0.
//       - Both clear on reset.
//     - Undefined: neither port nor counter exists; behaviour otherwise
//       identical.
// TESTING
//   1. Reset: rstn=0 for 3 cycles with in_valid=1 -> out_valid=0,
//      in_ready=0, level=0 throughout.
//      Cycle after release -> in_ready=1.
//   2. Streaming: DEPTH=4, out_ready=1, in_data=0..99 back-to-back.
//      -> out_data 0..99 in order, one per cycle after 1-cycle latency.
//      -> level stays at 1.
//   3. Fill: out_ready=0, feed 0,1,2,3.
//      -> level 1,2,3,4; almost_full=1 at level 3; in_ready=0 at level 4.
//      Then out_ready=1 -> drains 0,1,2,3, level 3,2,1,0.
//   4. Wrap: DEPTH=3, alternate 2 inserts / 1 remove for 20 beats.
//      -> output order equals input order; level never exceeds 3.
//   5. Mid-burst reset: level=3, assert rstn=0 for 1 cycle.
//      -> out_valid=0, level=0.
//      Next beat 0x55 appears alone at out_data.
//   6. PASS_STALL=1, level=1, out_ready=0 for 1 cycle.
//      -> in_ready=0 the following cycle.
//      -> perf_full_cnt increments if ELASTIC_BUF_PERF_EN is defined and
//         in_valid=1.

Source files
------------

// File: rtl/elastic_buf.sv
// In-order DEPTH-entry valid/ready elastic buffer with registered in_ready, out_valid and out_data.
// Latency: a beat inserted into an empty buffer is on out_data one cycle later; 1 beat/cycle sustained.
// Backpressure: in_ready drops when full (and with PASS_STALL=1 after an out_ready=0 cycle); optional ELASTIC_BUF_PERF_EN adds perf counters.
module elastic_buf #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 4,
   parameter int PASS_STALL   = 0,
   parameter int AFULL_THRESH = DEPTH - 1
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         in_valid,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        out_data,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         almost_full
`ifdef ELASTIC_BUF_PERF_EN
   ,
   output logic [31:0]                  perf_xfer_cnt,
   output logic [31:0]                  perf_full_cnt
`endif
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic [LW-1:0]         level_after_rm;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic                  almost_full_q, almost_full_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  insert;
   logic                  remove;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Handshakes, pointer/level bookkeeping and next values of the registered outputs.
   always_comb begin
      insert         = in_valid & in_ready_q;
      remove         = out_valid_q & out_ready;
      level_after_rm = level_q - LW'(remove);
      level_d        = level_after_rm + LW'(insert);
      wr_ptr_d       = insert ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d       = remove ? ptr_inc(rd_ptr_q) : rd_ptr_q;

      mem_d = mem_q;
      if (insert) begin
         mem_d[wr_ptr_q] = in_data;
      end

      // When nothing older survives this cycle the new beat goes straight to the
      // output register; otherwise the output shows the oldest stored entry.
      // An empty buffer keeps its last value on out_data.
      out_data_d = out_data_q;
      if (level_d != '0) begin
         if (level_after_rm == '0) begin
            out_data_d = in_data;
         end else begin
            out_data_d = mem_q[rd_ptr_d];
         end
      end

      out_valid_d   = (level_d != '0);
      in_ready_d    = (level_d != LW'(DEPTH)) & ((PASS_STALL == 0) | out_ready);
      almost_full_d = (level_d >= LW'(AFULL_THRESH));
   end

   // Control state and registered outputs; synchronous reset discards all beats.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         level_q       <= '0;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         almost_full_q <= 1'b0;
         out_data_q    <= '0;
      end else begin
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         level_q       <= level_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
         almost_full_q <= almost_full_d;
         out_data_q    <= out_data_d;
      end
   end

   // Payload storage; contents are qualified by the pointers so no reset is needed.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign level       = level_q;
   assign almost_full = almost_full_q;

`ifdef ELASTIC_BUF_PERF_EN
   logic [31:0] perf_xfer_cnt_q, perf_xfer_cnt_d;
   logic [31:0] perf_full_cnt_q, perf_full_cnt_d;

   // Count delivered beats and cycles where upstream is stalled; both wrap.
   always_comb begin
      perf_xfer_cnt_d = perf_xfer_cnt_q + (remove ? 32'd1 : 32'd0);
      perf_full_cnt_d = perf_full_cnt_q + ((in_valid & ~in_ready_q) ? 32'd1 : 32'd0);
   end

   // Performance counter registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         perf_xfer_cnt_q <= '0;
         perf_full_cnt_q <= '0;
      end else begin
         perf_xfer_cnt_q <= perf_xfer_cnt_d;
         perf_full_cnt_q <= perf_full_cnt_d;
      end
   end

   assign perf_xfer_cnt = perf_xfer_cnt_q;
   assign perf_full_cnt = perf_full_cnt_q;
`endif

endmodule

// File: tb/tb_elastic_buf.sv
// Directed bench for elastic_buf: three instances (DEPTH=4, DEPTH=3, DEPTH=4 with PASS_STALL=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Every comparison goes through chk(); one summary line at the end.
module tb_elastic_buf;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Instance A: DEPTH=4, PASS_STALL=0
   logic        a_rstn, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_af;
   logic [31:0] a_in_data, a_out_data;
   logic [2:0]  a_level;
   // Instance B: DEPTH=3
   logic        b_rstn, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_af;
   logic [31:0] b_in_data, b_out_data;
   logic [1:0]  b_level;
   // Instance C: DEPTH=4, PASS_STALL=1
   logic        c_rstn, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_af;
   logic [31:0] c_in_data, c_out_data;
   logic [2:0]  c_level;
`ifdef ELASTIC_BUF_PERF_EN
   logic [31:0] a_xfer, a_full, b_xfer, b_full, c_xfer, c_full;
`endif

   elastic_buf #(.DATA_WIDTH(32), .DEPTH(4), .PASS_STALL(0)) u_a (
      .clk(clk), .rstn(a_rstn), .in_valid(a_in_valid), .in_data(a_in_data),
      .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
      .out_ready(a_out_ready), .level(a_level), .almost_full(a_af)
`ifdef ELASTIC_BUF_PERF_EN
      , .perf_xfer_cnt(a_xfer), .perf_full_cnt(a_full)
`endif
   );

   elastic_buf #(.DATA_WIDTH(32), .DEPTH(3), .PASS_STALL(0)) u_b (
      .clk(clk), .rstn(b_rstn), .in_valid(b_in_valid), .in_data(b_in_data),
      .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
      .out_ready(b_out_ready), .level(b_level), .almost_full(b_af)
`ifdef ELASTIC_BUF_PERF_EN
      , .perf_xfer_cnt(b_xfer), .perf_full_cnt(b_full)
`endif
   );

   elastic_buf #(.DATA_WIDTH(32), .DEPTH(4), .PASS_STALL(1)) u_c (
      .clk(clk), .rstn(c_rstn), .in_valid(c_in_valid), .in_data(c_in_data),
      .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
      .out_ready(c_out_ready), .level(c_level), .almost_full(c_af)
`ifdef ELASTIC_BUF_PERF_EN
      , .perf_xfer_cnt(c_xfer), .perf_full_cnt(c_full)
`endif
   );

   logic [31:0] wq[$];
   int          m_level, sent, got;
   logic        ins, rem;

   initial begin
      a_rstn = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hDEAD; a_out_ready = 1'b1;
      b_rstn = 1'b0; b_in_valid = 1'b0; b_in_data = '0;       b_out_ready = 1'b0;
      c_rstn = 1'b0; c_in_valid = 1'b0; c_in_data = '0;       c_out_ready = 1'b1;

      // 1. Reset held 3 cycles with in_valid=1
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_out_valid", a_out_valid, 1'b0);
         chk("rst_in_ready", a_in_ready, 1'b0);
         chk("rst_level", a_level, 3'd0);
      end
      chk("rst_af", a_af, 1'b0);
      chk("rst_out_data", a_out_data, 32'd0);
      a_rstn = 1'b1; a_in_valid = 1'b0;
      step();
      chk("rel_in_ready", a_in_ready, 1'b1);
      chk("rel_out_valid", a_out_valid, 1'b0);

      // 2. Streaming 0..99 with out_ready=1
      a_out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         a_in_valid = 1'b1; a_in_data = i;
         step();
         chk("stream_dat", a_out_data, i);
         chk("stream_vld", a_out_valid, 1'b1);
         chk("stream_lvl", a_level, 3'd1);
         chk("stream_rdy", a_in_ready, 1'b1);
      end
      a_in_valid = 1'b0;
      step();
      chk("stream_end_lvl", a_level, 3'd0);
      chk("stream_end_vld", a_out_valid, 1'b0);
      chk("stream_hold_dat", a_out_data, 32'd99);
`ifdef ELASTIC_BUF_PERF_EN
      chk("perf_a_xfer", a_xfer, 32'd100);
      chk("perf_a_full", a_full, 32'd0);
`endif

      // 3. Fill to 4 with out_ready=0, then drain
      a_out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         a_in_valid = 1'b1; a_in_data = k;
         step();
         chk("fill_lvl", a_level, k + 1);
         chk("fill_af", a_af, (k + 1) >= 3);
         chk("fill_rdy", a_in_ready, (k + 1) != 4);
         chk("fill_dat", a_out_data, 32'd0);
      end
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("drain_dat", a_out_data, k);
         chk("drain_vld", a_out_valid, 1'b1);
         step();
         chk("drain_lvl", a_level, 3 - k);
      end
      chk("drain_end_vld", a_out_valid, 1'b0);
      chk("drain_end_rdy", a_in_ready, 1'b1);
      chk("drain_end_af", a_af, 1'b0);

      // 4. Wrap on DEPTH=3: 2 inserts / 1 remove, 20 beats, scoreboard
      b_rstn = 1'b1;
      step();
      chk("wrap_rel_rdy", b_in_ready, 1'b1);
      m_level = 0; sent = 0; got = 0;
      for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
         b_in_valid  = ((cyc % 3) != 2) && (sent < 20);
         b_out_ready = ((cyc % 3) == 2) || (sent >= 20);
         b_in_data   = sent * 7 + 3;
         chk("wrap_rdy", b_in_ready, m_level != 3);
         chk("wrap_vld", b_out_valid, m_level != 0);
         chk("wrap_lvl", b_level, m_level);
         chk("wrap_af", b_af, m_level >= 2);
         ins = b_in_valid && (m_level != 3);
         rem = b_out_ready && (m_level != 0);
         if (rem) begin
            chk("wrap_dat", b_out_data, wq[0]);
            void'(wq.pop_front());
            got++;
         end
         if (ins) begin
            wq.push_back(b_in_data);
            sent++;
         end
         m_level = m_level + int'(ins) - int'(rem);
         step();
      end
      chk("wrap_done", got, 20);
      b_in_valid = 1'b0; b_out_ready = 1'b0;

      // 5. Mid-burst reset at level 3
      a_out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a_in_valid = 1'b1; a_in_data = 10 + k;
         step();
      end
      chk("mid_pre_lvl", a_level, 3'd3);
      chk("mid_pre_af", a_af, 1'b1);
      a_rstn = 1'b0; a_in_valid = 1'b0;
      step();
      chk("mid_vld", a_out_valid, 1'b0);
      chk("mid_lvl", a_level, 3'd0);
      chk("mid_rdy", a_in_ready, 1'b0);
      chk("mid_af", a_af, 1'b0);
      chk("mid_dat", a_out_data, 32'd0);
      a_rstn = 1'b1;
      step();
      chk("mid_rel_rdy", a_in_ready, 1'b1);
      a_in_valid = 1'b1; a_in_data = 32'h55;
      step();
      chk("mid_55_vld", a_out_valid, 1'b1);
      chk("mid_55_dat", a_out_data, 32'h55);
      chk("mid_55_lvl", a_level, 3'd1);
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      step();
      chk("mid_alone_lvl", a_level, 3'd0);
      chk("mid_alone_vld", a_out_valid, 1'b0);

      // 6. PASS_STALL=1: out_ready low one cycle at level 1
      c_rstn = 1'b1;
      step();
      chk("ps_rel_rdy", c_in_ready, 1'b1);
      c_in_valid = 1'b1; c_in_data = 32'hA0;
      step();
      chk("ps_lvl1", c_level, 3'd1);
      chk("ps_rdy1", c_in_ready, 1'b1);
      c_in_valid = 1'b0; c_out_ready = 1'b0;
      step();
      chk("ps_stall_rdy", c_in_ready, 1'b0);
      chk("ps_stall_lvl", c_level, 3'd1);
      chk("ps_stall_dat", c_out_data, 32'hA0);
      c_in_valid = 1'b1; c_in_data = 32'hA1; c_out_ready = 1'b1;
      step();
      chk("ps_blocked_lvl", c_level, 3'd0);
      chk("ps_blocked_vld", c_out_valid, 1'b0);
      chk("ps_back_rdy", c_in_ready, 1'b1);
`ifdef ELASTIC_BUF_PERF_EN
      chk("perf_c_full", c_full, 32'd1);
      chk("perf_c_xfer", c_xfer, 32'd1);
`endif
      step();
      chk("ps_a1_dat", c_out_data, 32'hA1);
      chk("ps_a1_lvl", c_level, 3'd1);
      c_in_valid = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
